// File: rtl/cdc_sync_pkg.sv
// Shared limits and counter-sizing helper for the cdc_sync_bank synchroniser.
package cdc_sync_pkg;

  localparam int MIN_STAGES = 2;
  localparam int MAX_STAGES = 4;
  localparam int MAX_FILTER = 255;

  // Ceiling log2, never less than one bit so a counter always exists.
  function automatic int clog2(input int value);
    int result;
    int v;
    result = 0;
    v = value - 1;
    while (v > 0) begin
      result = result + 1;
      v = v >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

endpackage

// File: rtl/cdc_deglitch.sv
// One-channel stability filter: a level must differ for FILTER_CYCLES clocks
// before it is accepted; rise/fall pulse registers on the accepting edge.
module cdc_deglitch
  import cdc_sync_pkg::*;
#(
  parameter int   FILTER_CYCLES = 4,
  parameter logic RESET_BIT     = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int CNT_W = clog2(FILTER_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FILTER_CYCLES - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_level <= RESET_BIT;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_rise <= 1'b0;
      r_fall <= 1'b0;
      if (i_raw == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        r_cnt   <= '0;
        r_level <= i_raw;
        r_rise  <= i_raw;
        r_fall  <= ~i_raw;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/cdc_sync_bank.sv
// Multi-channel N-stage level synchroniser with registered rise/fall pulses.
// Optional glitch filter per channel when CDC_SYNC_FILTER_EN is defined.
module cdc_sync_bank
  import cdc_sync_pkg::*;
#(
  parameter int               WIDTH         = 4,
  parameter int               STAGES        = 2,
  parameter logic [WIDTH-1:0] RESET_VAL     = {WIDTH{1'b1}},
  parameter int               FILTER_CYCLES = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] async_in,
  output logic [WIDTH-1:0] sync_out,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall,
  output logic             any_change
);

  if (STAGES < MIN_STAGES || STAGES > MAX_STAGES) begin : g_bad_stages
    $error("cdc_sync_bank: STAGES must be within 2..4");
  end
  // Window is range-checked in both builds so the filter can be enabled without retuning.
  if (FILTER_CYCLES < 1 || FILTER_CYCLES > MAX_FILTER) begin : g_bad_filter
    $error("cdc_sync_bank: FILTER_CYCLES must be within 1..255");
  end
  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("cdc_sync_bank: WIDTH must be within 1..32");
  end

  logic [STAGES-1:0][WIDTH-1:0] r_stage;
  logic [WIDTH-1:0]             w_sync;
  logic [WIDTH-1:0]             w_rise;
  logic [WIDTH-1:0]             w_fall;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stage <= {STAGES{RESET_VAL}};
    end else begin
      r_stage <= {r_stage[STAGES-2:0], async_in};
    end
  end

`ifdef CDC_SYNC_FILTER_EN
  for (genvar i = 0; i < WIDTH; i++) begin : g_filter
    cdc_deglitch #(
      .FILTER_CYCLES (FILTER_CYCLES),
      .RESET_BIT     (RESET_VAL[i])
    ) u_deglitch (
      .clk     (clk),
      .reset   (reset),
      .i_raw   (r_stage[STAGES-1][i]),
      .o_level (w_sync[i]),
      .o_rise  (w_rise[i]),
      .o_fall  (w_fall[i])
    );
  end
`else
  logic [WIDTH-1:0] r_rise;
  logic [WIDTH-1:0] r_fall;

  // Pulses register on the same edge the last stage takes the new level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_rise <= '0;
      r_fall <= '0;
    end else begin
      r_rise <= r_stage[STAGES-2] & ~r_stage[STAGES-1];
      r_fall <= ~r_stage[STAGES-2] & r_stage[STAGES-1];
    end
  end

  assign w_sync = r_stage[STAGES-1];
  assign w_rise = r_rise;
  assign w_fall = r_fall;
`endif

  assign sync_out   = w_sync;
  assign rise       = w_rise;
  assign fall       = w_fall;
  assign any_change = |(w_rise | w_fall);

endmodule

// File: tb/tb_cdc_sync_bank.sv
// Bench for cdc_sync_bank: STAGES=2 instance checked against a vector table,
// STAGES=4 instance checked through a queue delayed by two extra cycles.
module tb_cdc_sync_bank;

  localparam logic [3:0] RV = 4'b1001;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] async_in;
  logic [3:0] so2, ri2, fa2, so4, ri4, fa4;
  logic       ac2, ac4;

  always #5 clk = ~clk;

  cdc_sync_bank #(.WIDTH(4), .STAGES(2), .RESET_VAL(RV), .FILTER_CYCLES(3)) dut2 (
    .clk(clk), .reset(reset), .async_in(async_in),
    .sync_out(so2), .rise(ri2), .fall(fa2), .any_change(ac2)
  );

  cdc_sync_bank #(.WIDTH(4), .STAGES(4), .RESET_VAL(RV), .FILTER_CYCLES(3)) dut4 (
    .clk(clk), .reset(reset), .async_in(async_in),
    .sync_out(so4), .rise(ri4), .fall(fa4), .any_change(ac4)
  );

  typedef struct {
    logic [3:0] in;
    logic [3:0] so;
    logic [3:0] ri;
    logic [3:0] fa;
  } vec_t;

  vec_t vecs[$];
  vec_t exp4_q[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string name, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d actual=%b expected=%b", name, idx, act, exp);
    end
  endtask

  task automatic add(input logic [3:0] in, input logic [3:0] so, input logic [3:0] ri, input logic [3:0] fa);
    vec_t v;
    v.in = in; v.so = so; v.ri = ri; v.fa = fa;
    vecs.push_back(v);
  endtask

  task automatic chk_quiet(input string tag, input int idx);
    chk({tag, "_so2"}, idx, so2, RV);
    chk({tag, "_rise2"}, idx, ri2, 4'b0000);
    chk({tag, "_fall2"}, idx, fa2, 4'b0000);
    chk({tag, "_any2"}, idx, {3'b000, ac2}, 4'b0000);
    chk({tag, "_so4"}, idx, so4, RV);
    chk({tag, "_rise4"}, idx, ri4, 4'b0000);
    chk({tag, "_fall4"}, idx, fa4, 4'b0000);
    chk({tag, "_any4"}, idx, {3'b000, ac4}, 4'b0000);
  endtask

  initial begin
    vec_t e;
    reset    = 1'b1;
    async_in = 4'b0110;
    repeat (3) @(posedge clk);
    #1;
    chk_quiet("reset", 0);

    @(negedge clk);
    async_in = RV;
    reset    = 1'b0;

    for (int k = 0; k < 10; k++) add(RV, RV, 4'b0000, 4'b0000);
`ifdef CDC_SYNC_FILTER_EN
    add(4'b1011, RV, 4'b0000, 4'b0000);
    add(4'b1011, RV, 4'b0000, 4'b0000);
    for (int k = 0; k < 5; k++) add(RV, RV, 4'b0000, 4'b0000);
    for (int k = 0; k < 4; k++) add(4'b1011, RV, 4'b0000, 4'b0000);
    add(4'b1011, 4'b1011, 4'b0010, 4'b0000);
    for (int k = 0; k < 4; k++) add(4'b1011, 4'b1011, 4'b0000, 4'b0000);
`else
    add(4'b1011, 4'b1001, 4'b0000, 4'b0000);
    add(4'b1011, 4'b1011, 4'b0010, 4'b0000);
    add(4'b1011, 4'b1011, 4'b0000, 4'b0000);
    add(4'b1001, 4'b1011, 4'b0000, 4'b0000);
    add(4'b1001, 4'b1001, 4'b0000, 4'b0010);
    add(4'b1100, 4'b1001, 4'b0000, 4'b0000);
    add(4'b1100, 4'b1100, 4'b0100, 4'b0001);
    add(4'b1100, 4'b1100, 4'b0000, 4'b0000);
    add(4'b1101, 4'b1100, 4'b0000, 4'b0000);
    add(4'b1100, 4'b1101, 4'b0001, 4'b0000);
    add(4'b1101, 4'b1100, 4'b0000, 4'b0001);
    add(4'b1100, 4'b1101, 4'b0001, 4'b0000);
    add(4'b1100, 4'b1100, 4'b0000, 4'b0001);
    add(4'b1100, 4'b1100, 4'b0000, 4'b0000);
    add(4'b1001, 4'b1100, 4'b0000, 4'b0000);
    add(4'b1001, 4'b1001, 4'b0001, 4'b0100);
    for (int k = 0; k < 3; k++) add(RV, RV, 4'b0000, 4'b0000);
`endif

    // The deeper chain lags by two cycles; seed the queue with its reset-level output.
    e.in = RV; e.so = RV; e.ri = 4'b0000; e.fa = 4'b0000;
    exp4_q.push_back(e);
    exp4_q.push_back(e);

    foreach (vecs[i]) begin
      @(negedge clk);
      async_in = vecs[i].in;
      exp4_q.push_back(vecs[i]);
      @(posedge clk);
      #1;
      chk("tbl_so2", i, so2, vecs[i].so);
      chk("tbl_rise2", i, ri2, vecs[i].ri);
      chk("tbl_fall2", i, fa2, vecs[i].fa);
      chk("tbl_any2", i, {3'b000, ac2}, {3'b000, |(vecs[i].ri | vecs[i].fa)});
      if (exp4_q.size() > 2) begin
        e = exp4_q.pop_front();
        chk("tbl_so4", i, so4, e.so);
        chk("tbl_rise4", i, ri4, e.ri);
        chk("tbl_fall4", i, fa4, e.fa);
        chk("tbl_any4", i, {3'b000, ac4}, {3'b000, |(e.ri | e.fa)});
      end
    end

    // Reset landing while a change is still inside the chains.
    @(negedge clk);
    async_in = RV;
    repeat (12) @(posedge clk);
    @(negedge clk);
    async_in = 4'b1011;
    @(posedge clk);
    #1;
    reset = 1'b1;
    #1;
    chk_quiet("midrst_async", 0);
    repeat (2) @(posedge clk);
    #1;
    chk_quiet("midrst_hold", 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk_quiet("midrst_first", 2);
    @(posedge clk);
    #1;
`ifdef CDC_SYNC_FILTER_EN
    chk("midrst_second_so2", 3, so2, RV);
    chk("midrst_second_rise2", 3, ri2, 4'b0000);
`else
    chk("midrst_second_so2", 3, so2, 4'b1011);
    chk("midrst_second_rise2", 3, ri2, 4'b0010);
`endif
    repeat (8) @(posedge clk);
    #1;
    chk("settled_so2", 4, so2, 4'b1011);
    chk("settled_so4", 4, so4, 4'b1011);
    reset = 1'b1;
    #1;
    chk("async_clear_so2", 5, so2, RV);
    chk("async_clear_so4", 5, so4, RV);
    #2;
    reset = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
